// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon-Say round sequencer.
// Optional input timeout is enabled by defining SIMON_TIMEOUT_EN.
package simon_pkg;

    typedef logic [1:0] code_t;

    localparam code_t CODE_A = 2'b00;
    localparam code_t CODE_B = 2'b01;
    localparam code_t CODE_C = 2'b10;
    localparam code_t CODE_D = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHOW_ON  = 3'd1,
        ST_SHOW_GAP = 3'd2,
        ST_WAIT_IN  = 3'd3,
        ST_WIN      = 3'd4,
        ST_LOSE     = 3'd5
    } state_t;

    function automatic logic [3:0] code_to_onehot(code_t c);
        logic [3:0] one;
        one = 4'b0001;
        return one << c;
    endfunction

endpackage

// File: rtl/simon_dwell_timer.sv
// Loadable down-counter that holds at zero; expired flags the final cycle
// of a dwell period. Shared by playback timing and the optional timeout.
module simon_dwell_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/simon_round_sequencer.sv
// Simon-Say game controller: plays a growing pattern prefix, then checks
// player input. Define SIMON_TIMEOUT_EN to lose after TIMEOUT_CYC idle clocks.
module simon_round_sequencer
    import simon_pkg::*;
#(
    parameter int SEQ_LEN     = 5,
    parameter int SHOW_CYCLES = 8,
    parameter int GAP_CYCLES  = 4,
    parameter int TIMEOUT_CYC = 64,
    localparam int IW = $clog2(SEQ_LEN + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          btn_valid,
    input  logic [1:0]    btn_code,
    output logic [IW-1:0] pat_idx,
    input  logic [1:0]    pat_code,
    output logic [3:0]    led,
    output logic [IW-1:0] round,
    output logic [IW-1:0] input_idx,
    output logic          awaiting_input,
    output logic          win,
    output logic          lose
);

    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_ON   = ST_SHOW_ON;
    localparam logic [2:0] S_GAP  = ST_SHOW_GAP;
    localparam logic [2:0] S_WAIT = ST_WAIT_IN;
    localparam logic [2:0] S_WIN  = ST_WIN;
    localparam logic [2:0] S_LOSE = ST_LOSE;

    localparam int MAX_AB = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int MAXC   = (MAX_AB > TIMEOUT_CYC) ? MAX_AB : TIMEOUT_CYC;
    localparam int CW     = $clog2(MAXC + 1);

    localparam logic [CW-1:0] LD_ON  = CW'(SHOW_CYCLES - 1);
    localparam logic [CW-1:0] LD_GAP = CW'(GAP_CYCLES - 1);
`ifdef SIMON_TIMEOUT_EN
    localparam logic [CW-1:0] LD_TO  = CW'(TIMEOUT_CYC - 1);
`else
    localparam logic [CW-1:0] LD_TO  = '0;
`endif
    localparam logic [IW-1:0] ONE    = IW'(1);
    localparam logic [IW-1:0] LAST_R = IW'(SEQ_LEN);

    logic [2:0]    state, state_d;
    logic [IW-1:0] round_d, pat_d, in_d;
    logic          tmr_load, tmr_exp;
    logic [CW-1:0] tmr_val;

    simon_dwell_timer #(.W(CW)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (tmr_load),
        .value   (tmr_val),
        .expired (tmr_exp)
    );

    always_comb begin
        state_d  = state;
        round_d  = round;
        pat_d    = pat_idx;
        in_d     = input_idx;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    state_d  = S_ON;
                    round_d  = ONE;
                    pat_d    = '0;
                    in_d     = '0;
                    tmr_load = 1'b1;
                    tmr_val  = LD_ON;
                end
            end
            S_ON: begin
                if (tmr_exp) begin
                    state_d  = S_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = LD_GAP;
                end
            end
            S_GAP: begin
                if (tmr_exp) begin
                    tmr_load = 1'b1;
                    if (pat_idx == round - ONE) begin
                        state_d = S_WAIT;
                        pat_d   = '0;
                        tmr_val = LD_TO;
                    end else begin
                        state_d = S_ON;
                        pat_d   = pat_idx + ONE;
                        tmr_val = LD_ON;
                    end
                end
            end
            S_WAIT: begin
                if (btn_valid) begin
                    if (btn_code != pat_code) begin
                        state_d = S_LOSE;
                    end else if (input_idx == round - ONE) begin
                        if (round == LAST_R) begin
                            state_d = S_WIN;
                        end else begin
                            state_d  = S_ON;
                            round_d  = round + ONE;
                            pat_d    = '0;
                            in_d     = '0;
                            tmr_load = 1'b1;
                            tmr_val  = LD_ON;
                        end
                    end else begin
                        in_d     = input_idx + ONE;
                        pat_d    = pat_idx + ONE;
                        tmr_load = 1'b1;
                        tmr_val  = LD_TO;
                    end
                end
`ifdef SIMON_TIMEOUT_EN
                else if (tmr_exp) begin
                    state_d = S_LOSE;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            round     <= '0;
            pat_idx   <= '0;
            input_idx <= '0;
        end else begin
            state     <= state_d;
            round     <= round_d;
            pat_idx   <= pat_d;
            input_idx <= in_d;
        end
    end

    assign led            = (state == S_ON) ? code_to_onehot(pat_code) : 4'b0000;
    assign awaiting_input = (state == S_WAIT);
    assign win            = (state == S_WIN);
    assign lose           = (state == S_LOSE);

endmodule
